// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types for the burst-locked round-robin stream arbiter.
package stream_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate so ptr+1 sits at bit 0, find first set, rotate back.
module stream_rr_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_onehot_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             any_o
);

    logic [N_REQ-1:0] rot;
    int               base;
    int               off;

    assign any_o = |req_i;

    always_comb begin
        base = (int'(ptr_i) + 1) % N_REQ;
        rot  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rot[k] = req_i[ID_W'((base + k) % N_REQ)];
        end
        // Scan downward so the lowest set bit of the rotated vector wins.
        off = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        gnt_id_o     = ID_W'((base + off) % N_REQ);
        gnt_onehot_o = '0;
        if (any_o) gnt_onehot_o[gnt_id_o] = 1'b1;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Burst-locked round-robin arbiter sharing one downstream write port among N_REQ streams.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16,
    parameter int ID_W      = $clog2(N_REQ),
    parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    areset_n,
    input  logic [N_REQ-1:0]        i_s_valid,
    output logic [N_REQ-1:0]        o_s_ready,
    input  logic [N_REQ*DATA_W-1:0] i_s_data,
    input  logic [N_REQ-1:0]        i_s_last,
    output logic                    o_m_valid,
    input  logic                    i_m_ready,
    output logic [DATA_W-1:0]       o_m_data,
    output logic [ID_W-1:0]         o_m_id,
    output logic                    o_m_last,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_busy
);

    state_e                       state_q;
    logic [N_REQ-1:0]             grant_q;
    logic [ID_W-1:0]              id_q;
    logic [ID_W-1:0]              prio_q;
    logic [CNT_W-1:0]             cnt_q;

    logic [N_REQ-1:0][DATA_W-1:0] s_data;
    logic                         busy;
    logic                         hs;
    logic                         term;
    logic [ID_W-1:0]              pick_ptr;
    logic [N_REQ-1:0]             pick_gnt;
    logic [ID_W-1:0]              pick_id;
    logic                         pick_any;

    assign s_data    = i_s_data;
    assign busy      = (state_q == ST_BURST);
    assign o_m_valid = busy & i_s_valid[id_q];
    assign o_m_data  = busy ? s_data[id_q] : '0;
    assign o_m_last  = o_m_valid & (i_s_last[id_q] | (cnt_q == CNT_W'(BURST_LEN - 1)));
    assign hs        = o_m_valid & i_m_ready;
    assign term      = hs & o_m_last;
    assign o_s_ready = (busy & i_m_ready) ? grant_q : '0;
    assign o_grant   = grant_q;
    assign o_m_id    = id_q;
    assign o_busy    = busy;

    // On re-arbitration the holder becomes the pointer, so it ranks last.
    assign pick_ptr = busy ? id_q : prio_q;

    stream_rr_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i        (i_s_valid),
        .ptr_i        (pick_ptr),
        .gnt_onehot_o (pick_gnt),
        .gnt_id_o     (pick_id),
        .any_o        (pick_any)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            prio_q  <= ID_W'(N_REQ - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q <= ST_BURST;
                        grant_q <= pick_gnt;
                        id_q    <= pick_id;
                    end
                end
                ST_BURST: begin
                    if (term) begin
                        prio_q <= id_q;
                        cnt_q  <= '0;
                        if (pick_any) begin
                            grant_q <= pick_gnt;
                            id_q    <= pick_id;
                        end else begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                        end
                    end else if (hs) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
